// File: rtl/zfp_blk_arb.sv
// zfp_blk_arb: two-requester block arbiter in front of find_emax.
// Ports: clk/reset, s0_fp_*, s1_fp_* in, m_fp_* merged out, m_tag_* block source id.
module zfp_blk_arb #(
  parameter int FP_W      = 64,
  parameter int BLOCK_LEN = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [FP_W-1:0] s0_fp_data,
  input  logic            s0_fp_valid,
  output logic            s0_fp_ready,
  input  logic [FP_W-1:0] s1_fp_data,
  input  logic            s1_fp_valid,
  output logic            s1_fp_ready,
  output logic [FP_W-1:0] m_fp_data,
  output logic            m_fp_valid,
  input  logic            m_fp_ready,
  output logic            m_tag_data,
  output logic            m_tag_valid,
  input  logic            m_tag_ready
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [7:0] CNT_END = 8'(BLOCK_LEN - 1);

  state_t     state;
  logic       grant;
  logic       last;
  logic [7:0] cnt;
  logic       tag_valid;
  logic       tag_data;

  logic       tag_free;
  logic       req_any;
  logic       start;
  logic       win;
  logic       beat;

  assign m_tag_valid = tag_valid;
  assign m_tag_data  = tag_data;

  // A new grant needs the tag slot free or freed this cycle,
  // so a stalled tag never gets overwritten.
  always_comb begin
    tag_free = !tag_valid || m_tag_ready;
    req_any  = s0_fp_valid || s1_fp_valid;
    start    = (state == IDLE) && tag_free && req_any;
    win      = 1'b0;
    unique case (1'b1)
      s0_fp_valid && s1_fp_valid:  win = !last;
      s1_fp_valid && !s0_fp_valid: win = 1'b1;
      default:                     win = 1'b0;
    endcase
  end

  // Merged stream: pure mux on grant, independent of m_tag_ready.
  always_comb begin
    m_fp_data   = grant ? s1_fp_data : s0_fp_data;
    m_fp_valid  = 1'b0;
    s0_fp_ready = 1'b0;
    s1_fp_ready = 1'b0;
    if (state == BUSY) begin
      m_fp_valid  = grant ? s1_fp_valid : s0_fp_valid;
      s0_fp_ready = !grant && m_fp_ready;
      s1_fp_ready = grant && m_fp_ready;
    end
  end

  assign beat = (state == BUSY) && m_fp_valid && m_fp_ready;

  // last resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      grant     <= 1'b0;
      last      <= 1'b1;
      cnt       <= 8'd0;
      tag_valid <= 1'b0;
      tag_data  <= 1'b0;
    end else begin
      if (tag_valid && m_tag_ready) begin
        tag_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (start) begin
            grant     <= win;
            last      <= win;
            cnt       <= 8'd0;
            tag_valid <= 1'b1;
            tag_data  <= win;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (beat) begin
            if (cnt == CNT_END) begin
              cnt   <= 8'd0;
              state <= IDLE;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_zfp_blk_arb.sv
// tb_zfp_blk_arb: directed vector bench for zfp_blk_arb.
// Drives two instances: BLOCK_LEN=4 (table + sequences) and BLOCK_LEN=1.
module tb_zfp_blk_arb;
  localparam int W = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [W-1:0] s0d, s1d, md;
  logic s0v, s0r, s1v, s1r, mv, mr, td, tv, tr;

  logic [W-1:0] b_s0d, b_s1d, b_md;
  logic b_s0v, b_s0r, b_s1v, b_s1r, b_mv, b_mr, b_td, b_tv, b_tr;

  zfp_blk_arb #(.FP_W(W), .BLOCK_LEN(4)) dut (
    .clk(clk), .reset(reset),
    .s0_fp_data(s0d), .s0_fp_valid(s0v), .s0_fp_ready(s0r),
    .s1_fp_data(s1d), .s1_fp_valid(s1v), .s1_fp_ready(s1r),
    .m_fp_data(md), .m_fp_valid(mv), .m_fp_ready(mr),
    .m_tag_data(td), .m_tag_valid(tv), .m_tag_ready(tr)
  );

  zfp_blk_arb #(.FP_W(W), .BLOCK_LEN(1)) dut1 (
    .clk(clk), .reset(reset),
    .s0_fp_data(b_s0d), .s0_fp_valid(b_s0v), .s0_fp_ready(b_s0r),
    .s1_fp_data(b_s1d), .s1_fp_valid(b_s1v), .s1_fp_ready(b_s1r),
    .m_fp_data(b_md), .m_fp_valid(b_mv), .m_fp_ready(b_mr),
    .m_tag_data(b_td), .m_tag_valid(b_tv), .m_tag_ready(b_tr)
  );

  typedef struct {
    logic        rst;
    logic        s0v;
    logic [15:0] s0d;
    logic        s1v;
    logic [15:0] s1d;
    logic        mr;
    logic        tr;
    logic        e_s0r;
    logic        e_s1r;
    logic        e_mv;
    logic        md_chk;
    logic [15:0] e_md;
    logic        e_tv;
    logic        e_td;
  } vec_t;

  vec_t tbl[$];
  int total = 0;
  int bad = 0;

  task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic add(logic rst, logic a_s0v, logic [15:0] a_s0d,
                     logic a_s1v, logic [15:0] a_s1d,
                     logic a_mr, logic a_tr,
                     logic x_s0r, logic x_s1r, logic x_mv,
                     logic x_mdc, logic [15:0] x_md,
                     logic x_tv, logic x_td);
    vec_t v;
    v.rst = rst; v.s0v = a_s0v; v.s0d = a_s0d;
    v.s1v = a_s1v; v.s1d = a_s1d; v.mr = a_mr; v.tr = a_tr;
    v.e_s0r = x_s0r; v.e_s1r = x_s1r; v.e_mv = x_mv;
    v.md_chk = x_mdc; v.e_md = x_md; v.e_tv = x_tv; v.e_td = x_td;
    tbl.push_back(v);
  endtask

  // Called just after a rising edge; pulses reset between edges.
  task automatic do_reset();
    s0v = 0; s1v = 0; s0d = '0; s1d = '0; mr = 1; tr = 1;
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  initial begin
    logic [15:0] a, b;
    bit w;
    int n0, n1, j;
    logic etag;
    logic [W-1:0] ev;

    reset = 1'b0;
    s0v = 0; s1v = 0; s0d = '0; s1d = '0; mr = 1; tr = 1;
    b_s0v = 0; b_s1v = 0; b_s0d = '0; b_s1d = '0; b_mr = 1; b_tr = 1;

    // single requester, values 1..4
    add(1, 1, 16'h1, 0, 16'h0, 1, 1, 0, 0, 0, 0, 16'h0, 0, 0);
    add(0, 1, 16'h1, 0, 16'h0, 1, 1, 1, 0, 1, 1, 16'h1, 1, 0);
    add(0, 1, 16'h2, 0, 16'h0, 1, 1, 1, 0, 1, 1, 16'h2, 0, 0);
    add(0, 1, 16'h3, 0, 16'h0, 1, 1, 1, 0, 1, 1, 16'h3, 0, 0);
    add(0, 1, 16'h4, 0, 16'h0, 1, 1, 1, 0, 1, 1, 16'h4, 0, 0);
    add(0, 0, 16'h0, 0, 16'h0, 1, 1, 0, 0, 0, 0, 16'h0, 0, 0);
    // tie for three blocks: tags 0,1,0 with one idle cycle each
    for (int bk = 0; bk < 3; bk++) begin
      w = (bk == 1);
      a = 16'h100 + 16'(bk * 8);
      b = 16'h200 + 16'(bk * 8);
      add(bk == 0, 1, a, 1, b, 1, 1, 0, 0, 0, 0, 16'h0, 0, bk == 2);
      for (int k = 0; k < 4; k++) begin
        a = 16'h101 + 16'(bk * 8 + k);
        b = 16'h201 + 16'(bk * 8 + k);
        add(0, 1, a, 1, b, 1, 1, !w, w, 1, 1, w ? b : a, k == 0, w);
      end
    end

    #12;
    chk("rst s0r", s0r, 0);
    chk("rst s1r", s1r, 0);
    chk("rst mv", mv, 0);
    chk("rst tv", tv, 0);
    chk("rst td", td, 0);
    chk("rst1 mv", b_mv, 0);
    chk("rst1 tv", b_tv, 0);
    @(posedge clk); #1;
    reset = 1'b1;

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      s0v = tbl[i].s0v; s0d = W'(tbl[i].s0d);
      s1v = tbl[i].s1v; s1d = W'(tbl[i].s1d);
      mr = tbl[i].mr; tr = tbl[i].tr;
      @(negedge clk);
      chk($sformatf("row%0d s0r", i), s0r, tbl[i].e_s0r);
      chk($sformatf("row%0d s1r", i), s1r, tbl[i].e_s1r);
      chk($sformatf("row%0d mv", i), mv, tbl[i].e_mv);
      if (tbl[i].md_chk)
        chk($sformatf("row%0d md", i), md, W'(tbl[i].e_md));
      chk($sformatf("row%0d tv", i), tv, tbl[i].e_tv);
      chk($sformatf("row%0d td", i), td, tbl[i].e_td);
      @(posedge clk); #1;
    end

    // backpressure: ready toggles, block spans 7 busy cycles
    do_reset();
    s0v = 1; s0d = 'h300;
    @(negedge clk);
    chk("bp idle mv", mv, 0);
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) begin
      mr = (k % 2 == 0);
      s0d = 'h300 + W'(k);
      @(negedge clk);
      chk($sformatf("bp%0d mv", k), mv, k < 7);
      chk($sformatf("bp%0d s0r", k), s0r, (k < 7) && mr);
      chk($sformatf("bp%0d s1r", k), s1r, 0);
      if (k < 7) chk($sformatf("bp%0d md", k), md, 'h300 + W'(k));
      @(posedge clk); #1;
    end
    s0v = 0; mr = 1;

    // tag stall: tag held 10 cycles, second grant waits for it
    do_reset();
    s0v = 1; s1v = 1; s0d = 'h400; s1d = 'h500; tr = 0;
    for (int k = 0; k < 12; k++) begin
      tr = (k >= 10);
      @(negedge clk);
      chk($sformatf("ts%0d tv", k), tv, k > 0);
      chk($sformatf("ts%0d td", k), td, k == 11);
      chk($sformatf("ts%0d mv", k), mv, (k >= 1 && k <= 4) || k == 11);
      chk($sformatf("ts%0d s1r", k), s1r, k == 11);
      if (k == 11) chk("ts md", md, 'h500);
      @(posedge clk); #1;
    end
    s0v = 0; s1v = 0; tr = 1;

    // reset in the middle of a requester-1 block
    do_reset();
    s1v = 1; s1d = 'h600;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rm busy s1r", s1r, 1);
    reset = 1'b0;
    #1;
    chk("rm s0r", s0r, 0);
    chk("rm s1r", s1r, 0);
    chk("rm mv", mv, 0);
    chk("rm tv", tv, 0);
    chk("rm td", td, 0);
    s0v = 1; s0d = 'h700;
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rm idle mv", mv, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rm tv", tv, 1);
    chk("rm td", td, 0);
    chk("rm s0r", s0r, 1);
    chk("rm s1r", s1r, 0);
    chk("rm md", md, 'h700);
    @(posedge clk); #1;
    s0v = 0; s1v = 0;

    // BLOCK_LEN=1: one beat per tag, tags alternate
    do_reset();
    b_s0v = 1; b_s1v = 1; b_mr = 1; b_tr = 1;
    n0 = 0; n1 = 0;
    for (int k = 0; k < 8; k++) begin
      b_s0d = 'h700 + W'(n0);
      b_s1d = 'h800 + W'(n1);
      @(negedge clk);
      if (k % 2 == 0) begin
        chk($sformatf("b1 %0d mv", k), b_mv, 0);
      end else begin
        j = k / 2;
        etag = j[0];
        ev = etag ? 'h800 + W'(j / 2) : 'h700 + W'(j / 2);
        chk($sformatf("b1 %0d mv", k), b_mv, 1);
        chk($sformatf("b1 %0d tv", k), b_tv, 1);
        chk($sformatf("b1 %0d td", k), b_td, etag);
        chk($sformatf("b1 %0d md", k), b_md, ev);
        chk($sformatf("b1 %0d s0r", k), b_s0r, !etag);
        chk($sformatf("b1 %0d s1r", k), b_s1r, etag);
      end
      if (b_s0v && b_s0r) n0++;
      if (b_s1v && b_s1r) n1++;
      @(posedge clk); #1;
    end
    chk("b1 n0", W'(n0), 2);
    chk("b1 n1", W'(n1), 2);
    b_s0v = 0; b_s1v = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/zfp_blk_arb.md
ZFP_BLK_ARB -- requirements
Module: zfp_blk_arb

Interface
REQ-001 SHALL have parameter FP_W, default 64, width of floating-point data words.
REQ-002 SHALL have parameter BLOCK_LEN, default 4, values per block; legal range 1..256.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports s0_fp_data / s0_fp_valid / s0_fp_ready: input FP_W / input 1 / output 1; requester 0 value stream.
REQ-006 SHALL have ports s1_fp_data / s1_fp_valid / s1_fp_ready: input FP_W / input 1 / output 1; requester 1 value stream.
REQ-007 SHALL have ports m_fp_data / m_fp_valid / m_fp_ready: output FP_W / output 1 / input 1; merged stream feeding find_emax.
REQ-008 SHALL have ports m_tag_data / m_tag_valid / m_tag_ready: output 1 / output 1 / input 1; source id of each granted block, one tag per block.

Function
REQ-009 SHALL use valid/ready handshakes on every stream; a transfer occurs in a cycle where valid and ready are both 1.
REQ-010 SHALL implement states IDLE and BUSY, with registers grant (1 bit), last (1 bit) and cnt (8 bits).
REQ-011 SHALL, in IDLE, drive s0_fp_ready=0, s1_fp_ready=0 and m_fp_valid=0.
REQ-012 SHALL leave IDLE only when the tag slot is free or being freed, i.e. (!m_tag_valid || m_tag_ready), and at least one sN_fp_valid is 1.
REQ-013 SHALL, on leaving IDLE with only one requester valid, grant that requester.
REQ-014 SHALL, on leaving IDLE with both requesters valid, grant !last (round-robin).
REQ-015 SHALL, on a grant edge, set grant and last to the winner, clear cnt, set m_tag_valid=1 with m_tag_data=winner, and enter BUSY.
REQ-016 SHALL, in BUSY, drive m_fp_data=s{grant}_fp_data, m_fp_valid=s{grant}_fp_valid and s{grant}_fp_ready=m_fp_ready combinationally, and hold the non-granted ready at 0.
REQ-017 SHALL increment cnt on each m_fp transfer in BUSY.
REQ-018 SHALL, on the transfer with cnt==BLOCK_LEN-1, return to IDLE and clear cnt; for BLOCK_LEN=1, the first transfer ends the block.
REQ-019 SHALL hold the grant for the whole block regardless of the other requester's valid; no preemption.
REQ-020 SHALL clear m_tag_valid on an m_tag transfer unless a new grant occurs in the same cycle, in which case the new grant wins.
REQ-021 SHALL hold m_tag_data stable while m_tag_valid=1 and m_tag_ready=0.
REQ-022 SHALL add exactly one IDLE cycle between consecutive blocks; throughput is BLOCK_LEN beats per BLOCK_LEN+1 cycles under continuous traffic.
REQ-023 SHALL allow a tag to remain unconsumed while its block streams; a following grant stalls in IDLE until that tag is accepted.
REQ-024 SHALL have no combinational path from m_tag_ready to any m_fp output.

Reset
REQ-025 SHALL, while reset=0, force state=IDLE, grant=0, last=1 (so requester 0 wins the first tie), cnt=0 and m_tag_valid=0, with m_tag_data=0.
REQ-026 SHALL, while reset=0, hold s0_fp_ready, s1_fp_ready and m_fp_valid at 0.
REQ-027 SHALL, on reset asserted mid-block, abandon the partial block without completing its remaining beats; on release, arbitration restarts fresh.

Verification
REQ-028 Single requester: s0 presents 4 values 0x1..0x4 and s1 is idle, sinks always ready -> tag 0 issued; m_fp carries 1,2,3,4 on cycles 2..5 after the request; back in IDLE on cycle 6.
REQ-029 Tie: both requesters valid continuously for 3 blocks -> tags 0,1,0; each block carries 4 beats from its own source only; s1_fp_ready=0 during requester-0 blocks.
REQ-030 Backpressure: m_fp_ready toggles 1,0,1,0 -> cnt advances only on transfer cycles; m_fp_data stays equal to the granted source.
REQ-031 Tag stall: m_tag_ready=0 for 10 cycles with both requesters valid -> the first block completes; the second grant waits until m_tag_ready=1, then tag 1 appears the following cycle.
REQ-032 Reset mid-block: reset low after beat 2 of a requester-1 block -> all readies and valids drop immediately; after release with both valid, requester 0 is granted first.
REQ-033 BLOCK_LEN=1: alternating requests -> one beat per tag; tags alternate 0,1,0,1; no lost or duplicated beats.
